// File: rtl/bus_master32.sv
// Register-bus initiator: accepts one command at a time and splits 32-bit accesses into
// two 16-bit bus cycles (low half word at A, high half word at A+2).
module bus_master32 #(
    parameter int unsigned RD_LATENCY = 1,
    parameter logic [15:0] IDLE_ADDR  = 16'hFFFF
) (
    input  logic        i_clk,
    input  logic        i_sclr,
    input  logic        i_cmd_valid,
    output logic        o_cmd_ready,
    input  logic        i_cmd_write,
    input  logic        i_cmd_wide,
    input  logic [15:0] i_cmd_addr,
    input  logic [3:0]  i_cmd_be,
    input  logic [31:0] i_cmd_wrdata,
    output logic        o_rsp_valid,
    output logic [31:0] o_rsp_rddata,
    output logic        o_busy,
    output logic [15:0] o_addr,
    output logic [1:0]  o_be,
    output logic        o_write,
    output logic [15:0] o_wrdata,
    input  logic [15:0] i_rddata
);

    typedef enum logic [2:0] {StIdle, StWrLo, StWrHi, StRdLo, StRdHi, StResp} state_e;

    localparam logic [2:0] LastCnt = 3'(RD_LATENCY);

    state_e      r_state;
    logic        r_wide;
    logic [15:0] r_base;
    logic [1:0]  r_be_hi;
    logic [15:0] r_wd_hi;
    logic [15:0] r_rd_lo;
    logic [2:0]  r_cnt;

    logic [15:0] w_base;
    logic [15:0] w_hi_addr;
    logic        w_rd_last;

    assign w_base      = {i_cmd_addr[15:1], 1'b0};
    assign w_hi_addr   = r_base + 16'd2;
    assign w_rd_last   = (r_cnt == LastCnt);
    assign o_cmd_ready = (r_state == StIdle) && !i_sclr;
    assign o_busy      = (r_state != StIdle);

    // Bus outputs are loaded on the edge that enters a state, so they are valid for the
    // whole of that state and switch directly from A to A+2 between halves.
    always_ff @(posedge i_clk) begin
        if (i_sclr) begin
            r_state      <= StIdle;
            r_wide       <= 1'b0;
            r_base       <= 16'h0000;
            r_be_hi      <= 2'b00;
            r_wd_hi      <= 16'h0000;
            r_rd_lo      <= 16'h0000;
            r_cnt        <= 3'd0;
            o_rsp_valid  <= 1'b0;
            o_rsp_rddata <= 32'h0000_0000;
            o_addr       <= IDLE_ADDR;
            o_be         <= 2'b00;
            o_write      <= 1'b0;
            o_wrdata     <= 16'h0000;
        end else begin
            o_rsp_valid <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (i_cmd_valid) begin
                        r_base  <= w_base;
                        r_wide  <= i_cmd_wide;
                        r_be_hi <= i_cmd_be[3:2];
                        r_wd_hi <= i_cmd_wrdata[31:16];
                        r_cnt   <= 3'd0;
                        o_addr  <= w_base;
                        if (i_cmd_write) begin
                            r_state  <= StWrLo;
                            o_be     <= i_cmd_be[1:0];
                            o_write  <= 1'b1;
                            o_wrdata <= i_cmd_wrdata[15:0];
                        end else begin
                            r_state <= StRdLo;
                            o_be    <= 2'b11;
                        end
                    end
                end
                StWrLo: begin
                    if (r_wide) begin
                        r_state  <= StWrHi;
                        o_addr   <= w_hi_addr;
                        o_be     <= r_be_hi;
                        o_wrdata <= r_wd_hi;
                    end else begin
                        r_state      <= StResp;
                        o_rsp_valid  <= 1'b1;
                        o_rsp_rddata <= 32'h0000_0000;
                        o_addr       <= IDLE_ADDR;
                        o_be         <= 2'b00;
                        o_write      <= 1'b0;
                        o_wrdata     <= 16'h0000;
                    end
                end
                StWrHi: begin
                    r_state      <= StResp;
                    o_rsp_valid  <= 1'b1;
                    o_rsp_rddata <= 32'h0000_0000;
                    o_addr       <= IDLE_ADDR;
                    o_be         <= 2'b00;
                    o_write      <= 1'b0;
                    o_wrdata     <= 16'h0000;
                end
                StRdLo: begin
                    if (!w_rd_last) begin
                        r_cnt <= r_cnt + 3'd1;
                    end else if (r_wide) begin
                        r_cnt   <= 3'd0;
                        r_rd_lo <= i_rddata;
                        r_state <= StRdHi;
                        o_addr  <= w_hi_addr;
                    end else begin
                        r_state      <= StResp;
                        o_rsp_valid  <= 1'b1;
                        o_rsp_rddata <= {16'h0000, i_rddata};
                        o_addr       <= IDLE_ADDR;
                        o_be         <= 2'b00;
                    end
                end
                StRdHi: begin
                    if (!w_rd_last) begin
                        r_cnt <= r_cnt + 3'd1;
                    end else begin
                        r_state      <= StResp;
                        o_rsp_valid  <= 1'b1;
                        o_rsp_rddata <= {i_rddata, r_rd_lo};
                        o_addr       <= IDLE_ADDR;
                        o_be         <= 2'b00;
                    end
                end
                StResp: begin
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: doc/bus_master32.md
Name: bus_master32

Overview:
- Initiator for the on-chip 16-bit register bus (addr/be/write/wrdata/rddata) used by the peripheral register blocks, e.g. the PWM/HV block.
- Accepts one command at a time from a valid/ready command port.
- Splits 32-bit ("wide") accesses into two 16-bit bus cycles: low half word at A, high half word at A+2.
- Returns one response per command. Sits between the host-side command decoder and the OR-ed register bus.

Parameters:
- RD_LATENCY, 1, cycles from addr presented to rddata valid at the master (slaves register rddata; legal range 1..7).
- IDLE_ADDR, 16'hFFFF, address driven while no bus cycle is active (must be unmapped).

Ports:
- clk  in  1  system clock
- sclr  in  1  synchronous active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_write  in  1  1 = write, 0 = read
- cmd_wide  in  1  1 = 32-bit access, 0 = 16-bit
- cmd_addr  in  16  byte address; bit 0 ignored (forced 0)
- cmd_be  in  4  byte enables; [1:0] low half word, [3:2] high half word (high ignored if !cmd_wide)
- cmd_wrdata  in  32  write data; [15:0] low, [31:16] high
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rddata  out  32  read data, valid with rsp_valid
- busy  out  1  state != IDLE
- addr  out  16  bus address
- be  out  2  bus byte enables
- write  out  1  bus write strobe, one cycle per half word
- wrdata  out  16  bus write data
- rddata  in  16  OR-ed bus read data

Behaviour:
- Reset values (sclr sampled high):
  - state = IDLE; cmd_ready = 0 during the sclr cycle.
  - rsp_valid = 0, rsp_rddata = 0, busy = 0.
  - addr = IDLE_ADDR, be = 0, write = 0, wrdata = 0.
- sclr mid-operation: the command is dropped with no rsp_valid. Bus outputs return to idle values the next cycle.
- All outputs are registered except cmd_ready and busy, which decode state: cmd_ready = (state == IDLE) && !sclr.
- States: IDLE, WR_LO, WR_HI, RD_LO, RD_HI, RESP.
- IDLE:
  - Bus idle.
  - On accept, latch the command, with base address A = {cmd_addr[15:1], 0}.
  - Go to WR_LO if cmd_write, else RD_LO.
- WR_LO (1 cycle):
  - addr = A, be = cb[1:0], wrdata = wd[15:0], write = 1.
  - Go to WR_HI if wide, else RESP.
- WR_HI (1 cycle):
  - addr = A+2 (mod 2^16), be = cb[3:2], wrdata = wd[31:16], write = 1.
  - Go to RESP.
- Half words with be = 0 are still issued.
- RD_LO:
  - addr = A, be = 2'b11, write = 0, held for RD_LATENCY+1 cycles (3-bit counter).
  - rddata is sampled at the end of the last cycle into rsp_rddata[15:0].
  - Go to RD_HI if wide, else RESP with rsp_rddata[31:16] = 0.
- RD_HI:
  - Same as RD_LO with addr = A+2; sample into rsp_rddata[31:16].
  - Go to RESP.
- RESP (1 cycle):
  - rsp_valid = 1, bus idle, cmd_ready = 0.
  - Next state IDLE; the next command can be accepted one cycle after RESP.
  - rsp_rddata holds its value until the next read completes; it is 0 after a write response.
- Latency from accept edge to rsp_valid:
  - narrow write 2 cycles; wide write 3 cycles;
  - narrow read RD_LATENCY+2 cycles; wide read 2*RD_LATENCY+3 cycles.
- Address wrap: A = 16'hFFFE wide → high half at 16'h0000.
- cmd_* inputs are ignored while not in IDLE. Changes on cmd_* after accept have no effect.
- addr must never glitch to a mapped address between halves: WR_LO→WR_HI and RD_LO→RD_HI switch directly from A to A+2.

Test Plan:
- Slave model at BAR 16'h0100 (32-bit regs at +0/+2). Wide write A=16'h0100, be=4'hF, data=32'h1234_5678 → two write cycles: (0100, 11, 5678) then (0102, 11, 1234); rsp_valid 3 cycles after accept, rsp_rddata=0.
- Wide read of the same register, RD_LATENCY=1 → addr 0100 for 2 cycles, 0102 for 2 cycles; rsp_valid at cycle 5 with rsp_rddata=32'h1234_5678.
- Narrow write be=4'b0001, data[7:0]=8'hAB at 16'h010C → single cycle with be=2'b01; narrow read back returns 32'h0000_00AB at cycle 3 (high half zero).
- Wrap: wide write A=16'hFFFF (bit0 forced) → cycles at FFFE then 0000. cmd_valid held continuously → cmd_ready low from accept through RESP; exactly one accept per command.
- sclr asserted during the 2nd cycle of RD_LO → no rsp_valid; next cycle addr=FFFF, be=0, write=0, busy=0; a new command is accepted the cycle after sclr drops.
- RD_LATENCY=3 build: narrow read holds addr 4 cycles; rddata sampled only at the 4th cycle (slave changes rddata at cycles 2–3 to decoy values, must be ignored); rsp_valid at cycle 5.
